pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Parametrised pipeline controller; successor to the fixed 5-stage hazard block. Drives per-register
//  advance/hold/bubble for an NSTAGE-deep in-order pipeline. Adds two things the old block lacked:
//  a pending-redirect latch, so a branch redirect that arrives during an outstanding ifetch is not
//  lost, and saturating stall/flush performance counters. Sits in core beside pcreg and the stage regs.
// PARAMETERS
//  NSTAGE      5   pipeline stages (0=fetch .. NSTAGE-1=writeback); legal range 3..8
//  REDIR_STAGE 1   stage that resolves branches/jumps; 1 <= REDIR_STAGE < NSTAGE-1
//  PC_W        64  PC width
//  CNT_W       32  perf counter width
// PORTS
//  clk           in   1            clock
//  reset         in   1            synchronous, active-high
//  stage_wait    in   NSTAGE       stage i cannot complete this cycle (imem/dmem/mul/load-use)
//  redir_valid   in   1            redirect request from REDIR_STAGE
//  redir_pc      in   PC_W         redirect target
//  ifetch_busy   in   1            ibus request outstanding (equals stage_wait[0] source)
//  pc_ctl        out  2            pc register control (stage_ctl_t)
//  stage_ctl     out  2*NSTAGE     stage_ctl[i]: register after stage i (stage_ctl_t)
//  pc_sel        out  1            1: next PC = pc_target; 0: predicted PC
//  pc_target     out  PC_W         redirect target (live or latched)
//  fetch_kill    out  1            mark the fetch result now returning as invalid
//  stall_cnt     out  CNT_W        cycles with any stage_wait set
//  flush_cnt     out  CNT_W        redirects accepted
// BEHAVIOUR
//  Encoding stage_ctl_t: ADV=2'b00 (load), HOLD=2'b01 (keep), BUBBLE=2'b10 (load invalid).
//  - Stall (combinational): k = highest index with stage_wait[k]=1.
//    pc_ctl=HOLD; stage_ctl[0..k-1]=HOLD; stage_ctl[k]=BUBBLE; stage_ctl[>k]=ADV.
//    With no wait set: everything ADV.
//  - Redirect accepted (redir_acc) iff redir_valid && no stage_wait[j] for j>=REDIR_STAGE.
//    When accepted: stage_ctl[0..REDIR_STAGE-1]=BUBBLE. This overrides HOLD from a fetch-only wait.
//    flush_cnt increments.
//  - A redirect that is not accepted is ignored; REDIR_STAGE is held and re-asserts it next cycle.
//  - Redirect FSM (states IDLE, PEND):
//    IDLE, redir_acc, !ifetch_busy: pc_sel=1, pc_target=redir_pc, pc_ctl=ADV; stay IDLE.
//    IDLE, redir_acc, ifetch_busy: latch redir_pc -> PEND; pc_ctl=HOLD; pc_sel=0.
//    PEND, ifetch_busy: pc_ctl=HOLD; stage_ctl[0]=BUBBLE.
//    PEND, !ifetch_busy: fetch_kill=1, pc_sel=1, pc_target=latched, pc_ctl=ADV, stage_ctl[0]=BUBBLE
//      -> IDLE.
//    PEND, new redir_acc: the latch is overwritten with the new redir_pc (youngest wins); stay PEND.
//    Same-cycle completion and new redirect: the new redir_pc is used directly; fetch_kill=1 -> IDLE.
//  - Latency: redirect to pc_sel is 0 cycles when fetch is idle. Otherwise pc_sel rises in the
//    cycle ifetch_busy falls.
//  - Counters: stall_cnt +1 per cycle with |stage_wait. Both counters saturate at all-ones and
//    never wrap.
//  - Reset: FSM=IDLE, latch=0, counters=0. During reset outputs are pc_ctl=ADV,
//    stage_ctl=all BUBBLE, pc_sel=0, pc_target=0, fetch_kill=0.
//    Reset mid-PEND discards the pending redirect.
//  - stage_wait bits above the pipeline (if any) are ignored; X on unused bits is tolerated.
// STRUCTURE
//  - pipes package: typedef enum logic [1:0] stage_ctl_t {ADV, HOLD, BUBBLE};
//    typedef enum logic redir_state_t {R_IDLE, R_PEND}.
//  - One sub-module: redir_hold (FSM + PC_W latch + fetch_kill). Priority/stall decode and
//    counters are inline in pipe_ctrl.
//  - Core wiring: PCWrite=pc_ctl, FWrite..MWrite=stage_ctl[0..3]. Drop-in for the hazard block
//    at NSTAGE=5.
// TESTING
//  1. No waits, no redirect, 10 cycles -> all ctl ADV, pc_sel=0, counters stay 0.
//  2. stage_wait=5'b01000 (dmem) -> pc/stage0..2 HOLD, stage3 BUBBLE, stage4 ADV; stall_cnt +1/cycle.
//  3. redir_valid, redir_pc=0x8000_0040, ifetch_busy=0 -> same cycle pc_sel=1,
//     pc_target=0x8000_0040, stage_ctl[0]=BUBBLE; flush_cnt=1.
//  4. Redirect to 0x80000100 with ifetch_busy=1 for 3 cycles -> PEND, pc HOLD; in the cycle busy
//     drops: fetch_kill=1, pc_sel=1, pc_target=0x80000100.
//  5. In PEND, second redirect 0x80000200 -> after busy drops pc_target=0x80000200; one kill only.
//  6. CNT_W=4, stall 20 cycles -> stall_cnt=15 (saturated); reset mid-PEND -> next cycle pc_sel=0,
//     counters 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller: per-register control encoding and
// the redirect-hold FSM states.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ADV    = 2'b00,
    HOLD   = 2'b01,
    BUBBLE = 2'b10
  } stage_ctl_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_PEND = 1'b1
  } redir_state_t;

  localparam int CTL_W      = 2;
  localparam int NSTAGE_MIN = 3;
  localparam int NSTAGE_MAX = 8;

endpackage

// File: rtl/redir_hold.sv
// Redirect hold: keeps a branch redirect that arrives while an ifetch is outstanding
// and replays it, killing the stale fetch, in the cycle the ibus goes idle.
module redir_hold
  import pipe_ctrl_pkg::*;
#(
  parameter int PC_W = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redir_acc,
  input  logic [PC_W-1:0] redir_pc,
  input  logic            ifetch_busy,
  output logic            pc_force,
  output logic [1:0]      pc_force_ctl,
  output logic            fetch_bubble,
  output logic            pc_sel,
  output logic [PC_W-1:0] pc_target,
  output logic            fetch_kill
);

  redir_state_t    state, state_nxt;
  logic [PC_W-1:0] latch_pc, latch_nxt;

  // NOTE: every signal driven here gets a default before the case, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    latch_nxt    = latch_pc;
    pc_force     = 1'b0;
    pc_force_ctl = ADV;
    fetch_bubble = 1'b0;
    pc_sel       = 1'b0;
    pc_target    = redir_pc;
    fetch_kill   = 1'b0;

    case (state)
      R_IDLE: begin
        if (redir_acc) begin
          pc_force = 1'b1;
          if (ifetch_busy) begin
            pc_force_ctl = HOLD;
            latch_nxt    = redir_pc;
            state_nxt    = R_PEND;
          end else begin
            pc_force_ctl = ADV;
            pc_sel       = 1'b1;
          end
        end
      end
      R_PEND: begin
        pc_force     = 1'b1;
        fetch_bubble = 1'b1;
        // A fresh redirect is younger than the latched one and always wins.
        pc_target    = redir_acc ? redir_pc : latch_pc;
        if (ifetch_busy) begin
          pc_force_ctl = HOLD;
          if (redir_acc) latch_nxt = redir_pc;
        end else begin
          pc_force_ctl = ADV;
          pc_sel       = 1'b1;
          fetch_kill   = 1'b1;
          state_nxt    = R_IDLE;
        end
      end
      default: state_nxt = R_IDLE;
    endcase

    if (reset) begin
      pc_force     = 1'b0;
      fetch_bubble = 1'b0;
      pc_sel       = 1'b0;
      pc_target    = '0;
      fetch_kill   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= R_IDLE;
      // NOTE: the target latch is a plain data register, but it is cleared so a
      // reset mid-PEND can never resurface a stale address.
      latch_pc <= '0;
    end else begin
      state    <= state_nxt;
      latch_pc <= latch_nxt;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Parametrised in-order pipeline controller: stall/redirect decode into per-register
// advance/hold/bubble, pending-redirect handling, and saturating perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE      = 5,
  parameter int REDIR_STAGE = 1,
  parameter int PC_W        = 64,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NSTAGE-1:0]     stage_wait,
  input  logic                  redir_valid,
  input  logic [PC_W-1:0]       redir_pc,
  input  logic                  ifetch_busy,
  output logic [1:0]            pc_ctl,
  output logic [2*NSTAGE-1:0]   stage_ctl,
  output logic                  pc_sel,
  output logic [PC_W-1:0]       pc_target,
  output logic                  fetch_kill,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  stage_ctl_t ctl [NSTAGE];
  stage_ctl_t pc_ctl_int;
  logic       any_wait;
  logic       later_wait;
  logic       redir_acc;
  logic       seen;
  logic       pc_force;
  logic [1:0] pc_force_ctl;
  logic       fetch_bubble;

  assign any_wait   = |stage_wait;
  // Only waits at or beyond the resolving stage block a redirect; younger ones get flushed.
  assign later_wait = |stage_wait[NSTAGE-1:REDIR_STAGE];
  assign redir_acc  = redir_valid && !later_wait;

  redir_hold #(
    .PC_W (PC_W)
  ) u_redir_hold (
    .clk          (clk),
    .reset        (reset),
    .redir_acc    (redir_acc),
    .redir_pc     (redir_pc),
    .ifetch_busy  (ifetch_busy),
    .pc_force     (pc_force),
    .pc_force_ctl (pc_force_ctl),
    .fetch_bubble (fetch_bubble),
    .pc_sel       (pc_sel),
    .pc_target    (pc_target),
    .fetch_kill   (fetch_kill)
  );

  always_comb begin
    seen = 1'b0;
    // Walk from writeback toward fetch: the oldest waiting stage bubbles, everything younger holds.
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (seen) begin
        ctl[i] = HOLD;
      end else if (stage_wait[i]) begin
        ctl[i] = BUBBLE;
        seen   = 1'b1;
      end else begin
        ctl[i] = ADV;
      end
    end

    for (int i = 0; i < REDIR_STAGE; i++) begin
      if (redir_acc) ctl[i] = BUBBLE;
    end
    if (fetch_bubble) ctl[0] = BUBBLE;

    pc_ctl_int = any_wait ? HOLD : ADV;
    if (pc_force) pc_ctl_int = stage_ctl_t'(pc_force_ctl);

    if (reset) begin
      pc_ctl_int = ADV;
      for (int i = 0; i < NSTAGE; i++) ctl[i] = BUBBLE;
    end
  end

  assign pc_ctl = pc_ctl_int;

  for (genvar g = 0; g < NSTAGE; g++) begin : g_pack
    assign stage_ctl[CTL_W*g +: CTL_W] = ctl[g];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (any_wait && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
      if (redir_acc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic, all compared each
// cycle against a behavioural model of the stall/redirect rules.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int NSTAGE      = 5;
  localparam int REDIR_STAGE = 1;
  localparam int PC_W        = 64;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                reset;
  logic [NSTAGE-1:0]   stage_wait;
  logic                redir_valid;
  logic [PC_W-1:0]     redir_pc;
  logic                ifetch_busy;
  logic [1:0]          pc_ctl;
  logic [2*NSTAGE-1:0] stage_ctl;
  logic                pc_sel;
  logic [PC_W-1:0]     pc_target;
  logic                fetch_kill;
  logic [CNT_W-1:0]    stall_cnt;
  logic [CNT_W-1:0]    flush_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state: a pending redirect (if any) and plain event tallies.
  bit              m_pend;
  logic [PC_W-1:0] m_pend_pc;
  int              m_stalls;
  int              m_flushes;

  pipe_ctrl #(
    .NSTAGE      (NSTAGE),
    .REDIR_STAGE (REDIR_STAGE),
    .PC_W        (PC_W),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stage_wait  (stage_wait),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .ifetch_busy (ifetch_busy),
    .pc_ctl      (pc_ctl),
    .stage_ctl   (stage_ctl),
    .pc_sel      (pc_sel),
    .pc_target   (pc_target),
    .fetch_kill  (fetch_kill),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive after negedge, compare combinational and counter outputs, advance model at posedge.
  task automatic step(input logic rst, input logic [NSTAGE-1:0] sw, input logic rv,
                      input logic [PC_W-1:0] rpc, input logic busy);
    int              k;
    bit              acc;
    stage_ctl_t      e_ctl [NSTAGE];
    stage_ctl_t      e_pc;
    bit              e_sel;
    bit              e_kill;
    logic [PC_W-1:0] e_tgt;

    @(negedge clk);
    reset       = rst;
    stage_wait  = sw;
    redir_valid = rv;
    redir_pc    = rpc;
    ifetch_busy = busy;
    #1;

    k = -1;
    for (int i = 0; i < NSTAGE; i++) if (sw[i]) k = i;
    acc = rv;
    for (int i = REDIR_STAGE; i < NSTAGE; i++) if (sw[i]) acc = 1'b0;

    e_sel  = 1'b0;
    e_kill = 1'b0;
    e_tgt  = '0;
    if (rst) begin
      e_pc = ADV;
      for (int i = 0; i < NSTAGE; i++) e_ctl[i] = BUBBLE;
    end else begin
      for (int i = 0; i < NSTAGE; i++)
        e_ctl[i] = (k < 0 || i > k) ? ADV : ((i == k) ? BUBBLE : HOLD);
      e_pc = (k >= 0) ? HOLD : ADV;
      if (acc) for (int i = 0; i < REDIR_STAGE; i++) e_ctl[i] = BUBBLE;
      if (!m_pend) begin
        if (acc && !busy) begin
          e_sel = 1'b1;
          e_tgt = rpc;
          e_pc  = ADV;
        end else if (acc) begin
          e_pc = HOLD;
        end
      end else begin
        e_ctl[0] = BUBBLE;
        if (busy) begin
          e_pc = HOLD;
        end else begin
          e_kill = 1'b1;
          e_sel  = 1'b1;
          e_pc   = ADV;
          e_tgt  = acc ? rpc : m_pend_pc;
        end
      end
    end

    check($sformatf("c%0d pc_ctl", cyc), pc_ctl, e_pc);
    for (int i = 0; i < NSTAGE; i++)
      check($sformatf("c%0d stage_ctl%0d", cyc, i), stage_ctl[2*i +: 2], e_ctl[i]);
    check($sformatf("c%0d pc_sel", cyc), pc_sel, e_sel);
    check($sformatf("c%0d fetch_kill", cyc), fetch_kill, e_kill);
    if (rst || e_sel) check($sformatf("c%0d pc_target", cyc), pc_target, e_tgt);
    if (!rst) begin
      check($sformatf("c%0d stall_cnt", cyc), stall_cnt, m_stalls);
      check($sformatf("c%0d flush_cnt", cyc), flush_cnt, m_flushes);
    end

    @(posedge clk);
    cyc++;
    if (rst) begin
      m_pend    = 1'b0;
      m_pend_pc = '0;
      m_stalls  = 0;
      m_flushes = 0;
    end else begin
      if (k >= 0 && m_stalls < CNT_MAX) m_stalls++;
      if (acc && m_flushes < CNT_MAX) m_flushes++;
      if (!m_pend) begin
        if (acc && busy) begin
          m_pend    = 1'b1;
          m_pend_pc = rpc;
        end
      end else if (busy) begin
        if (acc) m_pend_pc = rpc;
      end else begin
        m_pend = 1'b0;
      end
    end
  endtask

  initial begin
    logic [NSTAGE-1:0] sw;
    logic              busy;

    reset       = 1'b1;
    stage_wait  = '0;
    redir_valid = 1'b0;
    redir_pc    = '0;
    ifetch_busy = 1'b0;
    m_pend      = 1'b0;
    m_pend_pc   = '0;
    m_stalls    = 0;
    m_flushes   = 0;

    step(1'b1, '0, 1'b0, '0, 1'b0);
    step(1'b1, '0, 1'b0, '0, 1'b0);

    // Quiet pipeline.
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, '0, 1'b0);

    // dmem wait in stage 3.
    for (int i = 0; i < 4; i++) step(1'b0, 5'b01000, 1'b0, '0, 1'b0);

    // Redirect with fetch idle, plus one with a younger-stage wait that must not block it.
    step(1'b0, '0, 1'b1, 64'h8000_0040, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    #1 check("flush_after_redir", flush_cnt, 4'd1);
    step(1'b0, 5'b00001, 1'b1, 64'h8000_0080, 1'b0);
    step(1'b0, 5'b00100, 1'b1, 64'h8000_00c0, 1'b0);

    // Redirect during outstanding fetch, released after 3 busy cycles.
    step(1'b0, 5'b00001, 1'b1, 64'h8000_0100, 1'b1);
    step(1'b0, 5'b00001, 1'b0, '0, 1'b1);
    step(1'b0, 5'b00001, 1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0);

    // Youngest redirect wins while pending; then same-cycle release with a new redirect.
    step(1'b0, 5'b00001, 1'b1, 64'h8000_0180, 1'b1);
    step(1'b0, 5'b00001, 1'b1, 64'h8000_0200, 1'b1);
    step(1'b0, 5'b00001, 1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, 5'b00001, 1'b1, 64'h8000_0300, 1'b1);
    step(1'b0, '0, 1'b1, 64'h8000_0340, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0);

    // Counter saturation, then reset while a redirect is pending.
    for (int i = 0; i < 20; i++) step(1'b0, 5'b00100, 1'b0, '0, 1'b0);
    #1 check("stall_sat", stall_cnt, 4'hf);
    step(1'b0, 5'b00001, 1'b1, 64'h8000_0400, 1'b1);
    step(1'b1, 5'b00001, 1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      busy = ($urandom_range(0, 2) == 0);
      sw   = '0;
      sw[0] = busy;
      for (int i = 1; i < NSTAGE; i++) sw[i] = ($urandom_range(0, 7) == 0);
      step(($urandom_range(0, 80) == 0), sw, ($urandom_range(0, 3) == 0),
           {$urandom, $urandom}, busy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
